// File: rtl/image_write_packer.sv
// Packs serial RGB565 pixels into ten-lane groups and issues one DRAM write per group.
// One frame of FRAME_WORDS pixels is written per start command; pixel n lands at byte address 4n.
module image_write_packer #(
   parameter int FRAME_WORDS = 65520
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        we,
   output logic [17:0] a1,
   output logic [17:0] a2,
   output logic [17:0] a3,
   output logic [17:0] a4,
   output logic [17:0] a5,
   output logic [17:0] a6,
   output logic [17:0] a7,
   output logic [17:0] a8,
   output logic [17:0] a9,
   output logic [17:0] a10,
   output logic [15:0] wd1,
   output logic [15:0] wd2,
   output logic [15:0] wd3,
   output logic [15:0] wd4,
   output logic [15:0] wd5,
   output logic [15:0] wd6,
   output logic [15:0] wd7,
   output logic [15:0] wd8,
   output logic [15:0] wd9,
   output logic [15:0] wd10,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

   state_t      state_q;
   logic [3:0]  lane_q;
   logic [16:0] group_base_q;
   logic [15:0] lane_data_q [10];
   logic [17:0] addr_q [10];
   logic [15:0] wd_q [10];
   logic        we_q;
   logic        in_ready_q;
   logic        busy_q;
   logic        done_q;

   logic [16:0] group_base_d;
   logic        last_group;

   assign group_base_d = group_base_q + 17'd10;
   assign last_group   = (group_base_d == 17'(FRAME_WORDS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         lane_q       <= '0;
         group_base_q <= '0;
         we_q         <= 1'b0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         for (int k = 0; k < 10; k++) begin
            lane_data_q[k] <= '0;
            addr_q[k]      <= '0;
            wd_q[k]        <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q      <= S_FILL;
                  lane_q       <= '0;
                  group_base_q <= '0;
                  in_ready_q   <= 1'b1;
                  busy_q       <= 1'b1;
               end
            end
            S_FILL: begin
               if (in_valid) begin
                  lane_data_q[lane_q] <= in_data;
                  if (lane_q == 4'd9) begin
                     // The tenth pixel bypasses its lane register so the write issues next cycle.
                     state_q    <= S_WRITE;
                     lane_q     <= '0;
                     in_ready_q <= 1'b0;
                     we_q       <= 1'b1;
                     for (int k = 0; k < 10; k++) begin
                        addr_q[k] <= {group_base_q[15:0] + 16'(k), 2'b00};
                        wd_q[k]   <= (k == 9) ? in_data : lane_data_q[k];
                     end
                  end else begin
                     lane_q <= lane_q + 4'd1;
                  end
               end
            end
            S_WRITE: begin
               we_q         <= 1'b0;
               group_base_q <= group_base_d;
               if (last_group) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= S_FILL;
                  in_ready_q <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign we       = we_q;
   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;

   assign a1  = addr_q[0];
   assign a2  = addr_q[1];
   assign a3  = addr_q[2];
   assign a4  = addr_q[3];
   assign a5  = addr_q[4];
   assign a6  = addr_q[5];
   assign a7  = addr_q[6];
   assign a8  = addr_q[7];
   assign a9  = addr_q[8];
   assign a10 = addr_q[9];

   assign wd1  = wd_q[0];
   assign wd2  = wd_q[1];
   assign wd3  = wd_q[2];
   assign wd4  = wd_q[3];
   assign wd5  = wd_q[4];
   assign wd6  = wd_q[5];
   assign wd7  = wd_q[6];
   assign wd8  = wd_q[7];
   assign wd9  = wd_q[8];
   assign wd10 = wd_q[9];

endmodule

// File: tb/tb_image_write_packer.sv
// Directed bench for image_write_packer with a 30-pixel frame (three groups).
module tb_image_write_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        we;
   logic        busy;
   logic        done;
   logic [17:0] a1, a2, a3, a4, a5, a6, a7, a8, a9, a10;
   logic [15:0] wd1, wd2, wd3, wd4, wd5, wd6, wd7, wd8, wd9, wd10;

   logic [17:0] a_w [10];
   logic [15:0] wd_w [10];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   image_write_packer #(.FRAME_WORDS(30)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .we(we),
      .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5),
      .a6(a6), .a7(a7), .a8(a8), .a9(a9), .a10(a10),
      .wd1(wd1), .wd2(wd2), .wd3(wd3), .wd4(wd4), .wd5(wd5),
      .wd6(wd6), .wd7(wd7), .wd8(wd8), .wd9(wd9), .wd10(wd10),
      .busy(busy), .done(done)
   );

   assign a_w[0] = a1;  assign a_w[1] = a2;  assign a_w[2] = a3;  assign a_w[3] = a4;
   assign a_w[4] = a5;  assign a_w[5] = a6;  assign a_w[6] = a7;  assign a_w[7] = a8;
   assign a_w[8] = a9;  assign a_w[9] = a10;
   assign wd_w[0] = wd1; assign wd_w[1] = wd2; assign wd_w[2] = wd3; assign wd_w[3] = wd4;
   assign wd_w[4] = wd5; assign wd_w[5] = wd6; assign wd_w[6] = wd7; assign wd_w[7] = wd8;
   assign wd_w[8] = wd9; assign wd_w[9] = wd10;

   typedef struct {
      logic [15:0] first;
      bit          toggle;
      bit          poke;
      logic [17:0] a1;
      logic [17:0] a10;
      logic [15:0] wd1;
      logic [15:0] wd10;
      bit          last;
   } grp_t;

   grp_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Feeds ten pixels; returns in the WRITE cycle that follows the tenth accept.
   task automatic send_group(input logic [15:0] first, input bit toggle, input bit poke);
      int sent = 0;
      int cyc = 0;
      int early_we = 0;
      while (sent < 10 && cyc < 100) begin
         if (we) early_we++;
         in_valid = !toggle || (cyc % 2 == 0);
         in_data  = first + 16'(sent);
         start    = poke && (cyc == 3);
         if (in_valid && in_ready) sent++;
         step();
         cyc++;
      end
      in_valid = 1'b0;
      start    = poke;
      chk("accepted_count", sent, 10);
      chk("we_before_10th", early_we, 0);
      chk("we_after_10th", {31'd0, we}, 1);
      chk("ready_in_write", {31'd0, in_ready}, 0);
   endtask

   task automatic check_group(input logic [17:0] ea1, input logic [15:0] ewd1,
                              input logic [17:0] ea10, input logic [15:0] ewd10);
      chk("a10", {14'd0, a10}, {14'd0, ea10});
      chk("wd10", {16'd0, wd10}, {16'd0, ewd10});
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("addr_lane%0d", k + 1), {14'd0, a_w[k]}, {14'd0, ea1 + 18'(4 * k)});
         chk($sformatf("data_lane%0d", k + 1), {16'd0, wd_w[k]}, {16'd0, ewd1 + 16'(k)});
      end
   endtask

   initial begin
      tbl[0] = '{16'h0000, 1'b0, 1'b0, 18'h00000, 18'h00024, 16'h0000, 16'h0009, 1'b0};
      tbl[1] = '{16'h000A, 1'b1, 1'b0, 18'h00028, 18'h0004C, 16'h000A, 16'h0013, 1'b0};
      tbl[2] = '{16'h0014, 1'b0, 1'b1, 18'h00050, 18'h00074, 16'h0014, 16'h001D, 1'b1};
      tbl[3] = '{16'h0100, 1'b1, 1'b1, 18'h00000, 18'h00024, 16'h0100, 16'h0109, 1'b0};
      tbl[4] = '{16'h0200, 1'b0, 1'b1, 18'h00028, 18'h0004C, 16'h0200, 16'h0209, 1'b0};
      tbl[5] = '{16'h0300, 1'b1, 1'b0, 18'h00050, 18'h00074, 16'h0300, 16'h0309, 1'b1};

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
      repeat (3) step();
      rst = 1'b0;
      // Pixels offered while idle must not be consumed.
      in_valid = 1'b1; in_data = 16'hDEAD;
      repeat (5) step();
      chk("rst_we", {31'd0, we}, 0);
      chk("rst_ready", {31'd0, in_ready}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      for (int k = 0; k < 10; k++) begin
         chk("rst_addr", {14'd0, a_w[k]}, 0);
         chk("rst_data", {16'd0, wd_w[k]}, 0);
      end

      in_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_ready", {31'd0, in_ready}, 1);
      chk("start_busy", {31'd0, busy}, 1);

      for (int i = 0; i < 6; i++) begin
         send_group(tbl[i].first, tbl[i].toggle, tbl[i].poke);
         check_group(tbl[i].a1, tbl[i].wd1, tbl[i].a10, tbl[i].wd10);
         step();
         start = 1'b0;
         chk("we_one_cycle", {31'd0, we}, 0);
         chk("a1_hold", {14'd0, a1}, {14'd0, tbl[i].a1});
         if (tbl[i].last) begin
            chk("done_pulse", {31'd0, done}, 1);
            chk("busy_in_done", {31'd0, busy}, 1);
            chk("ready_in_done", {31'd0, in_ready}, 0);
            start = (i == 2);
            step();
            chk("done_cleared", {31'd0, done}, 0);
            chk("busy_after_done", {31'd0, busy}, 0);
            chk("ready_idle", {31'd0, in_ready}, 0);
            if (i == 2) begin
               step();
               start = 1'b0;
               chk("restart_ready", {31'd0, in_ready}, 1);
               chk("restart_busy", {31'd0, busy}, 1);
            end
         end else begin
            chk("ready_after_write", {31'd0, in_ready}, 1);
         end
      end

      repeat (3) step();
      chk("no_second_done", {31'd0, done}, 0);

      // Abort a partly filled group with reset asserted together with start.
      start = 1'b1;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      for (int j = 0; j < 7; j++) begin
         in_data = 16'h0500 + 16'(j);
         step();
      end
      rst = 1'b1; start = 1'b1;
      step();
      rst = 1'b0; start = 1'b0;
      chk("abort_we", {31'd0, we}, 0);
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_ready", {31'd0, in_ready}, 0);
      chk("abort_a1_reset", {14'd0, a1}, 0);
      begin
         int we_seen = 0;
         for (int j = 0; j < 10; j++) begin
            step();
            if (we) we_seen++;
         end
         chk("abort_no_write", we_seen, 0);
      end
      chk("abort_still_idle", {31'd0, busy}, 0);

      in_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      send_group(16'h0AB0, 1'b0, 1'b0);
      check_group(18'h00000, 16'h0AB0, 18'h00024, 16'h0AB9);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
